// File: rtl/fetch_align_buffer.sv
// Fetch front end: word-aligned instruction reads into a halfword FIFO, realigned issue to IF/ID.
// RVC (16-bit) alignment is enabled by defining FAB_COMPRESSED_EN; otherwise every instruction is 32-bit.
module fetch_align_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_data_o,
    output logic        inst_compressed_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]    fifo_q [DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    head_pc_q, head_pc_d;
    logic           drop_low_q, drop_low_d;
    logic           outstanding_q, outstanding_d;
    logic           kill_q, kill_d;
    logic           mem_req_q, mem_req_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic           inst_valid_q, inst_valid_d;
    logic [31:0]    inst_pc_q, inst_pc_d;
    logic [31:0]    inst_data_q, inst_data_d;
    logic           inst_compressed_q, inst_compressed_d;

    logic [15:0]    head0, head1;
    logic           head_is32, head_ready;
    logic           push_lo, push_hi;
    logic [1:0]     push_cnt, pop_cnt;
    logic           unused_pc_bits;

    assign head0 = fifo_q[rd_ptr_q];
    assign head1 = fifo_q[rd_ptr_q + AW'(1)];
`ifdef FAB_COMPRESSED_EN
    assign head_is32 = (head0[1:0] == 2'b11);
`else
    assign head_is32 = 1'b1;
`endif
    assign head_ready     = head_is32 ? (count_q >= CW'(2)) : (count_q >= CW'(1));
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    always_comb begin
        rd_ptr_d          = rd_ptr_q;
        wr_ptr_d          = wr_ptr_q;
        count_d           = count_q;
        fetch_pc_d        = fetch_pc_q;
        head_pc_d         = head_pc_q;
        drop_low_d        = drop_low_q;
        outstanding_d     = outstanding_q;
        kill_d            = kill_q;
        inst_valid_d      = inst_valid_q;
        inst_pc_d         = inst_pc_q;
        inst_data_d       = inst_data_q;
        inst_compressed_d = inst_compressed_q;
        push_lo           = 1'b0;
        push_hi           = 1'b0;
        pop_cnt           = 2'd0;
        push_cnt          = 2'd0;
        mem_req_d         = 1'b0;
        mem_addr_d        = mem_addr_q;

        if (redirect_i) begin
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            fetch_pc_d    = {redirect_pc_i[31:2], 2'b00};
`ifdef FAB_COMPRESSED_EN
            drop_low_d    = redirect_pc_i[1];
            head_pc_d     = {redirect_pc_i[31:1], 1'b0};
`else
            drop_low_d    = 1'b0;
            head_pc_d     = {redirect_pc_i[31:2], 2'b00};
`endif
            // A response still owed by memory (or granted right now) belongs to the old path.
            kill_d        = (outstanding_q && !mem_rvalid_i) || (mem_req_q && mem_gnt_i);
            outstanding_d = kill_d;
            inst_valid_d  = 1'b0;
        end else begin
            if (mem_rvalid_i && outstanding_q) begin
                outstanding_d = 1'b0;
                if (kill_q) begin
                    kill_d = 1'b0;
                end else begin
                    push_hi    = 1'b1;
                    push_lo    = !drop_low_q;
                    drop_low_d = 1'b0;
                end
            end
            if (mem_req_q && mem_gnt_i) begin
                outstanding_d = 1'b1;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            // Output stage refills whenever it is empty or being consumed.
            if (!inst_valid_q || inst_ready_i) begin
                inst_valid_d = head_ready;
                if (head_ready) begin
                    pop_cnt           = head_is32 ? 2'd2 : 2'd1;
                    inst_pc_d         = head_pc_q;
                    inst_data_d       = head_is32 ? {head1, head0} : {16'h0, head0};
                    inst_compressed_d = !head_is32;
                    head_pc_d         = head_pc_q + (head_is32 ? 32'd4 : 32'd2);
                end
            end
            push_cnt = {1'b0, push_lo} + {1'b0, push_hi};
            count_d  = count_q + CW'(push_cnt) - CW'(pop_cnt);
            rd_ptr_d = rd_ptr_q + AW'(pop_cnt);
            wr_ptr_d = wr_ptr_q + AW'(push_cnt);
        end

        mem_req_d  = !redirect_i && !outstanding_d && ((CW'(DEPTH) - count_d) >= CW'(2));
        mem_addr_d = fetch_pc_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            count_q           <= '0;
            fetch_pc_q        <= {RESET_PC[31:2], 2'b00};
            head_pc_q         <= RESET_PC;
            drop_low_q        <= 1'b0;
            outstanding_q     <= 1'b0;
            kill_q            <= 1'b0;
            mem_req_q         <= 1'b0;
            mem_addr_q        <= {RESET_PC[31:2], 2'b00};
            inst_valid_q      <= 1'b0;
            inst_pc_q         <= RESET_PC;
            inst_data_q       <= 32'h0;
            inst_compressed_q <= 1'b0;
        end else begin
            rd_ptr_q          <= rd_ptr_d;
            wr_ptr_q          <= wr_ptr_d;
            count_q           <= count_d;
            fetch_pc_q        <= fetch_pc_d;
            head_pc_q         <= head_pc_d;
            drop_low_q        <= drop_low_d;
            outstanding_q     <= outstanding_d;
            kill_q            <= kill_d;
            mem_req_q         <= mem_req_d;
            mem_addr_q        <= mem_addr_d;
            inst_valid_q      <= inst_valid_d;
            inst_pc_q         <= inst_pc_d;
            inst_data_q       <= inst_data_d;
            inst_compressed_q <= inst_compressed_d;
        end
    end

    // Halfword storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_lo) begin
            fifo_q[wr_ptr_q]          <= mem_rdata_i[15:0];
            fifo_q[wr_ptr_q + AW'(1)] <= mem_rdata_i[31:16];
        end else if (push_hi) begin
            fifo_q[wr_ptr_q]          <= mem_rdata_i[31:16];
        end
    end

    assign mem_req_o         = mem_req_q;
    assign mem_addr_o        = mem_addr_q;
    assign inst_valid_o      = inst_valid_q;
    assign inst_pc_o         = inst_pc_q;
    assign inst_data_o       = inst_data_q;
    assign inst_compressed_o = inst_compressed_q;

endmodule
